uart_rx: RTL

// - 8N1 UART receiver, the receive-side counterpart of the core's UART transmitter; same bit timing.
// - Oversamples UART_RX with clk: detects the start edge, samples each bit at mid-bit, checks the stop bit.
// - Delivers each byte through a one-entry valid/ready holding register to core logic.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_sync2.sv | 29 ++
 rtl/uart_rx.sv | 132 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: data width and receiver state encoding.
// Imported by the receiver and the transmitter so both agree on frame width.
package uart_pkg;

  localparam int unsigned UART_DATA_W = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } rx_state_t;

endpackage : uart_pkg

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input.
// The reset value is a parameter so idle-high and idle-low inputs can both reuse it.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge value of its source, independent of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule : uart_sync2

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-edge detection, mid-bit sampling, stop-bit check,
// and a one-entry valid/ready holding register towards core logic.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_PER_HALF_BIT = 868
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   UART_RX,
  output logic [UART_DATA_W-1:0] rdata,
  output logic                   rdata_valid,
  input  logic                   rdata_ready,
  output logic                   ferr,
  output logic                   overrun
);

  localparam logic [31:0] E_HALF = 32'(CLK_PER_HALF_BIT - 1);
  localparam logic [31:0] E_BIT  = 32'(2 * CLK_PER_HALF_BIT - 1);

  logic rx_s;

  rx_state_t              state_q, state_d;
  logic [31:0]            ctr_q, ctr_d;
  logic [2:0]             idx_q, idx_d;
  logic [UART_DATA_W-1:0] shreg_q, shreg_d;
  logic [UART_DATA_W-1:0] rdata_q, rdata_d;
  logic                   valid_q, valid_d;
  logic                   ferr_q, ferr_d;
  logic                   overrun_q, overrun_d;
  logic                   stop_hit;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (UART_RX),
    .q    (rx_s)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      ctr_q     <= '0;
      idx_q     <= '0;
      shreg_q   <= '0;
      rdata_q   <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctr_q     <= ctr_d;
      idx_q     <= idx_d;
      shreg_q   <= shreg_d;
      rdata_q   <= rdata_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      overrun_q <= overrun_d;
    end
  end

  // Next state, bit timing and shift register.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    state_d  = state_q;
    ctr_d    = ctr_q;
    idx_d    = idx_q;
    shreg_d  = shreg_q;
    stop_hit = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        ctr_d = '0;
        if (!rx_s) state_d = S_START;
      end
      S_START: begin
        if (ctr_q == E_HALF) begin
          ctr_d   = '0;
          idx_d   = '0;
          // Line back high at start-bit centre means a glitch, not a frame.
          state_d = rx_s ? S_IDLE : S_DATA;
        end else begin
          ctr_d = ctr_q + 32'd1;
        end
      end
      S_DATA: begin
        if (ctr_q == E_BIT) begin
          ctr_d   = '0;
          shreg_d = {rx_s, shreg_q[UART_DATA_W-1:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_STOP;
        end else begin
          ctr_d = ctr_q + 32'd1;
        end
      end
      S_STOP: begin
        // Leaving at the stop-bit centre tolerates a short stop bit from the sender.
        if (ctr_q == E_BIT) begin
          ctr_d    = '0;
          stop_hit = 1'b1;
          state_d  = S_IDLE;
        end else begin
          ctr_d = ctr_q + 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Holding register and status pulses.
  always_comb begin
    rdata_d   = rdata_q;
    valid_d   = valid_q;
    ferr_d    = stop_hit & ~rx_s;
    overrun_d = 1'b0;
    if (valid_q && rdata_ready) valid_d = 1'b0;
    if (stop_hit && rx_s) begin
      if (!valid_q || rdata_ready) begin
        rdata_d = shreg_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  assign rdata       = rdata_q;
  assign rdata_valid = valid_q;
  assign ferr        = ferr_q;
  assign overrun     = overrun_q;

endmodule : uart_rx
